// File: rtl/seq_add_sub_nbits.sv
// rtl/seq_add_sub_nbits.sv - multi-cycle adder/subtractor, CHUNK bits per clock with registered carry
// Operands are latched on start; results and flags are only updated on the final chunk.
module seq_add_sub_nbits #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_next;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             carry_next;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] chunk_sum;
  logic             last_chunk;

  // b_q already holds ~b in subtract mode, so one adder serves both operations
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
    {carry_next, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    sum_next = sum_q;
    for (int k = 0; k < N; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        sum_next[k*CHUNK +: CHUNK] = chunk_sum;
      end
    end
  end

  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      s_o     <= '0;
      cout_o  <= 1'b0;
      ovf_o   <= 1'b0;
      zero_o  <= 1'b0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i;
            cnt_q   <= '0;
            busy_o  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= carry_next;
          cnt_q   <= cnt_q + 1'b1;
          if (last_chunk) begin
            state_q <= DONE;
            done_o  <= 1'b1;
            s_o     <= sum_next;
            cout_o  <= carry_next;
            ovf_o   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_next[WIDTH-1] != a_q[WIDTH-1]);
            zero_o  <= (sum_next == '0);
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_add_sub_nbits.sv
// tb/tb_seq_add_sub_nbits.sv - randomized and directed bench for seq_add_sub_nbits
// Four configurations share stimulus; directed scenarios check the (8,4) instance.
module tb_seq_add_sub_nbits;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic [31:0] a_in  = '0;
  logic [31:0] b_in  = '0;

  int n_vec = 0;
  int n_err = 0;

  logic        busy_w [4];
  logic        done_w [4];
  logic        cout_w [4];
  logic        ovf_w  [4];
  logic        zero_w [4];
  logic [31:0] s_w    [4];
  logic [7:0]  s_8x4, s_8x8;
  logic [15:0] s_16x4;
  logic [31:0] s_32x8;

  assign s_w[0] = {24'd0, s_8x4};
  assign s_w[1] = {24'd0, s_8x8};
  assign s_w[2] = {16'd0, s_16x4};
  assign s_w[3] = s_32x8;

  int w_tab [4] = '{8, 8, 16, 32};
  int n_tab [4] = '{2, 1, 4, 4};

  seq_add_sub_nbits #(.WIDTH(8), .CHUNK(4)) u_8x4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a_in[7:0]), .b_i(b_in[7:0]),
    .busy_o(busy_w[0]), .done_o(done_w[0]), .s_o(s_8x4), .cout_o(cout_w[0]), .ovf_o(ovf_w[0]),
    .zero_o(zero_w[0]));
  seq_add_sub_nbits #(.WIDTH(8), .CHUNK(8)) u_8x8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a_in[7:0]), .b_i(b_in[7:0]),
    .busy_o(busy_w[1]), .done_o(done_w[1]), .s_o(s_8x8), .cout_o(cout_w[1]), .ovf_o(ovf_w[1]),
    .zero_o(zero_w[1]));
  seq_add_sub_nbits #(.WIDTH(16), .CHUNK(4)) u_16x4 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a_in[15:0]), .b_i(b_in[15:0]),
    .busy_o(busy_w[2]), .done_o(done_w[2]), .s_o(s_16x4), .cout_o(cout_w[2]), .ovf_o(ovf_w[2]),
    .zero_o(zero_w[2]));
  seq_add_sub_nbits #(.WIDTH(32), .CHUNK(8)) u_32x8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .sub_i(sub), .a_i(a_in), .b_i(b_in),
    .busy_o(busy_w[3]), .done_o(done_w[3]), .s_o(s_32x8), .cout_o(cout_w[3]), .ovf_o(ovf_w[3]),
    .zero_o(zero_w[3]));

  // Reference: plain integer arithmetic on the unsigned and signed readings of the operands
  function automatic void ref_model(input int w, input bit sb, input longint a, input longint b,
                                    output longint s, output bit cout, output bit ovf,
                                    output bit zero);
    longint m    = longint'(1) << w;
    longint half = longint'(1) << (w - 1);
    longint sa   = (a >= half) ? a - m : a;
    longint sbv  = (b >= half) ? b - m : b;
    longint full;
    longint sr;
    if (sb) begin
      full = a - b;
      cout = (a >= b);
      sr   = sa - sbv;
    end else begin
      full = a + b;
      cout = (full >= m);
      sr   = sa + sbv;
    end
    s    = full & (m - 1);
    ovf  = (sr > half - 1) || (sr < -half);
    zero = (s == 0);
  endfunction

  // Launches one operation from IDLE and observes the (8,4) instance for a bounded window
  task automatic do_op(input bit sb, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busy_cyc, output int done_cyc);
    start = 1'b1; sub = sb; a_in = a; b_in = b;
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_cyc = 0; done_cyc = 0;
    for (int j = 0; j < 12; j++) begin
      if (busy_w[0]) busy_cyc++;
      if (done_w[0]) begin
        done_cyc++;
        if (lat < 0) lat = j;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if ({busy_w[i], done_w[i], cout_w[i], ovf_w[i], zero_w[i]} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_flags[%0d]: got %b required 00000", i,
                 {busy_w[i], done_w[i], cout_w[i], ovf_w[i], zero_w[i]});
      end
      n_vec++;
      if (s_w[i] !== 32'd0) begin
        n_err++;
        $display("FAIL reset_sum[%0d]: got %h required 0", i, s_w[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_ovf();
    int lat, bc, dc;
    do_op(1'b0, 32'h3C, 32'h55, lat, bc, dc);
    n_vec++; if (lat !== 2)  begin n_err++; $display("FAIL add_latency: got %0d required 2", lat); end
    n_vec++; if (dc !== 1)   begin n_err++; $display("FAIL add_done_width: got %0d required 1", dc); end
    n_vec++; if (bc !== 3)   begin n_err++; $display("FAIL add_busy_cycles: got %0d required 3", bc); end
    n_vec++; if (s_w[0] !== 32'h91) begin n_err++; $display("FAIL add_sum: got %h required 91", s_w[0]); end
    n_vec++;
    if ({cout_w[0], ovf_w[0], zero_w[0]} !== 3'b010) begin
      n_err++;
      $display("FAIL add_flags: got %b required 010", {cout_w[0], ovf_w[0], zero_w[0]});
    end
  endtask

  task automatic test_carry_chain();
    int lat, bc, dc;
    do_op(1'b0, 32'hFF, 32'h01, lat, bc, dc);
    n_vec++; if (s_w[0] !== 32'h00) begin n_err++; $display("FAIL carry_sum: got %h required 00", s_w[0]); end
    n_vec++;
    if ({cout_w[0], ovf_w[0], zero_w[0]} !== 3'b101) begin
      n_err++;
      $display("FAIL carry_flags: got %b required 101", {cout_w[0], ovf_w[0], zero_w[0]});
    end
  endtask

  task automatic test_sub();
    int lat, bc, dc;
    do_op(1'b1, 32'h10, 32'h20, lat, bc, dc);
    n_vec++; if (s_w[0] !== 32'hF0) begin n_err++; $display("FAIL sub_borrow_sum: got %h required f0", s_w[0]); end
    n_vec++;
    if ({cout_w[0], ovf_w[0], zero_w[0]} !== 3'b000) begin
      n_err++;
      $display("FAIL sub_borrow_flags: got %b required 000", {cout_w[0], ovf_w[0], zero_w[0]});
    end
    do_op(1'b1, 32'h80, 32'h01, lat, bc, dc);
    n_vec++; if (s_w[0] !== 32'h7F) begin n_err++; $display("FAIL sub_ovf_sum: got %h required 7f", s_w[0]); end
    n_vec++;
    if ({cout_w[0], ovf_w[0], zero_w[0]} !== 3'b110) begin
      n_err++;
      $display("FAIL sub_ovf_flags: got %b required 110", {cout_w[0], ovf_w[0], zero_w[0]});
    end
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [31:0] s_first = '0;
    start = 1'b1; sub = 1'b0; a_in = 32'h01; b_in = 32'h02;
    @(negedge clk);
    a_in = 32'hAA; b_in = 32'h55; sub = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (done_w[0]) begin
        if (first < 0) begin
          first = j; s_first = s_w[0];
        end else if (second < 0) begin
          second = j;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    n_vec++; if (first !== 2) begin n_err++; $display("FAIL b2b_first_latency: got %0d required 2", first); end
    n_vec++; if (s_first !== 32'h03) begin n_err++; $display("FAIL b2b_ignore_inputs: got %h required 03", s_first); end
    n_vec++; if (second !== 6) begin n_err++; $display("FAIL b2b_second_done: got %0d required 6", second); end
    n_vec++; if (s_w[0] !== 32'h55) begin n_err++; $display("FAIL b2b_second_sum: got %h required 55", s_w[0]); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_abort();
    int lat, bc, dc, dones = 0;
    start = 1'b1; sub = 1'b0; a_in = 32'h3C; b_in = 32'h55;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0]} !== 5'b0 || s_w[0] !== 32'd0) begin
      n_err++;
      $display("FAIL abort_outputs: got flags %b sum %h required 0", 
               {busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0]}, s_w[0]);
    end
    for (int j = 0; j < 8; j++) begin
      if (done_w[0]) dones++;
      @(negedge clk);
    end
    n_vec++; if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses required 0", dones); end
    do_op(1'b0, 32'h07, 32'h09, lat, bc, dc);
    n_vec++; if (s_w[0] !== 32'h10) begin n_err++; $display("FAIL after_abort_sum: got %h required 10", s_w[0]); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL after_abort_latency: got %0d required 2", lat); end
  endtask

  task automatic test_random_sweep();
    for (int v = 0; v < 1000; v++) begin
      bit          sb;
      logic [31:0] a, b;
      int          lat [4];
      sb = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = a;
        1: a = 32'd0;
        2: b = 32'hFFFF_FFFF;
        3: begin a = 32'h8000_0080; b = 32'h0000_0001; end
        default: ;
      endcase
      start = 1'b1; sub = sb; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) lat[i] = -1;
      for (int j = 0; j < 7; j++) begin
        for (int i = 0; i < 4; i++) if (done_w[i] && lat[i] < 0) lat[i] = j;
        @(negedge clk);
      end
      for (int i = 0; i < 4; i++) begin
        longint      es;
        bit          ec, eo, ez;
        logic [31:0] mask;
        mask = (w_tab[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << w_tab[i]) - 32'd1);
        ref_model(w_tab[i], sb, longint'(a & mask), longint'(b & mask), es, ec, eo, ez);
        n_vec++;
        if (lat[i] !== n_tab[i]) begin
          n_err++;
          $display("FAIL sweep_latency[%0d] v%0d: got %0d required %0d", i, v, lat[i], n_tab[i]);
        end
        n_vec++;
        if (s_w[i] !== 32'(es)) begin
          n_err++;
          $display("FAIL sweep_sum[%0d] v%0d sub=%0d a=%h b=%h: got %h required %h",
                   i, v, sb, a & mask, b & mask, s_w[i], 32'(es));
        end
        n_vec++;
        if ({cout_w[i], ovf_w[i], zero_w[i]} !== {ec, eo, ez}) begin
          n_err++;
          $display("FAIL sweep_flags[%0d] v%0d sub=%0d a=%h b=%h: got %b required %b",
                   i, v, sb, a & mask, b & mask, {cout_w[i], ovf_w[i], zero_w[i]}, {ec, eo, ez});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_abort();
    test_random_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_add_sub_nbits.md
Name: seq_add_sub_nbits

Overview:
Multi-cycle, parametrised adder/subtractor for the calculator datapath. It adds or subtracts two WIDTH-bit operands CHUNK bits per clock, rippling the carry through a register between cycles. It uses a start/done handshake and reports carry, signed overflow and zero flags. It sits between the operand registers and the result/display logic, and replaces the purely combinational n-bit adder on wide configurations where a single-cycle ripple is too slow.

Parameters:
- WIDTH, 8, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. Must divide WIDTH exactly. CHUNK = WIDTH gives single-chunk operation.
- N (localparam), WIDTH/CHUNK, number of chunk cycles.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- sub_i  input  1  0 = a+b, 1 = a-b; latched with start.
- a_i  input  WIDTH  operand A; latched with start.
- b_i  input  WIDTH  operand B; latched with start.
- busy_o  output  1  high in RUN and DONE.
- done_o  output  1  one-cycle pulse; results valid and stable.
- s_o  output  WIDTH  result, modulo 2^WIDTH.
- cout_o  output  1  final carry out. In sub mode, 1 = no borrow (a >= b unsigned).
- ovf_o  output  1  two's-complement signed overflow.
- zero_o  output  1  s_o == 0.

Behaviour:
- Reset (rst_i high at a clock edge): state IDLE; busy_o, done_o, s_o, cout_o, ovf_o, zero_o = 0; chunk counter = 0; carry = 0. Reset has priority over every other event, including mid-RUN. An aborted operation never asserts done_o.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i = 1 at an edge:
  - latch A = a_i, B' = sub_i ? ~b_i : b_i, mode = sub_i, carry = sub_i, counter = 0;
  - go to RUN.
- IDLE, start_i = 0: remain in IDLE.
- RUN, each edge:
  - compute {c, chunk} = A[k] + B'[k] + carry, where k = counter and [k] selects bits k*CHUNK .. k*CHUNK+CHUNK-1;
  - store chunk into the internal sum register; carry = c; counter + 1.
  - When counter == N-1 at that edge, go to DONE.
- DONE entry (the same edge as the last chunk): load the output registers.
  - s_o = full sum;
  - cout_o = final carry;
  - ovf_o = (A[MSB] == B'[MSB]) && (s[MSB] != A[MSB]);
  - zero_o = (s == 0).
- DONE, next edge: go to IDLE. done_o = 1 exactly during the DONE cycle.
- Latency: done_o is high in the cycle that begins N edges after the edge that sampled start_i. Back-to-back throughput is one operation per N+2 cycles (start held high continuously).
- s_o and flags are held from DONE entry until the next DONE entry or reset. Partial sums never appear on s_o.
- start_i, sub_i, a_i and b_i are ignored in RUN and DONE. Changing them mid-operation does not affect the result.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, CHUNK=4, add 0x3C+0x55: s_o=0x91, cout_o=0, ovf_o=1, zero_o=0. done_o is high exactly 2 edges after the start edge, for 1 cycle. busy_o is high for 3 cycles.
- Add 0xFF+0x01: s_o=0x00, cout_o=1, zero_o=1, ovf_o=0. Also tests carry propagation across the chunk boundary.
- Sub 0x10-0x20: s_o=0xF0, cout_o=0, ovf_o=0. Then sub 0x80-0x01: s_o=0x7F, cout_o=1, ovf_o=1.
- Start add 0x01+0x02, then during RUN drive a_i=0xAA, b_i=0x55, sub_i=1, start_i=1. Required: s_o=0x03. With start held high, the second operation is accepted only at the first IDLE edge and its done_o follows N+2 cycles after the first done_o.
- Assert rst_i one cycle into RUN: all outputs 0 on the next cycle, no done_o pulse. A following add 0x07+0x09 gives 0x10.
- Parameter sweep over (8,8), (16,4), (32,8): 1000 random vectors per configuration, both modes. Check s_o, cout_o, ovf_o and zero_o against a behavioural a±b model, and check latency = N.
